swarm_move_controller: RTL and testbench
========================================

// Module: swarm_move_controller
// PURPOSE
//  Frame-synchronous motion scheduler for the invader swarm bracket object.
//  Drives topLeftX/topLeftY of the swarm rectangle object and steps them once every N frames, classic invaders style.
//  Steps sideways; at a screen edge it drops one row and reverses.
//  Sits between the VGA frame-timing source and the swarm object; flags landing to game control.
// PARAMETERS
//  INIT_X        64   reset/restart left X of swarm (signed 11b)
//  INIT_Y        32   reset/restart top Y of swarm (signed 11b)
//  SWARM_WIDTH   352  swarm bracket width, pixels
//  SWARM_HEIGHT  160  swarm bracket height, pixels
//  STEP_X        8    horizontal step, pixels
//  STEP_Y        16   vertical drop on edge hit, pixels
//  STEP_FRAMES   30   frames between steps (>=1)
//  LEFT_BOUND    0    leftmost legal X
//  RIGHT_BOUND   640  rightmost legal X+SWARM_WIDTH (exclusive edge)
//  BOTTOM_LIMIT  400  landing line; landed when Y+SWARM_HEIGHT >= BOTTOM_LIMIT
// PORTS
//  clk           in   1   system clock
//  resetN        in   1   asynchronous active-low reset
//  startOfFrame  in   1   one-clk pulse per VGA frame
//  enable        in   1   game running; 0 freezes swarm
//  restart       in   1   one-clk pulse: return to INIT position, IDLE
//  aliveCount    in   6   live invaders (present only with SWARM_SPEEDUP_EN)
//  topLeftX      out  11  signed swarm X to bracket object
//  topLeftY      out  11  signed swarm Y to bracket object
//  stepPulse     out  1   one-clk pulse on the cycle position changes
//  dirRight      out  1   1 = moving right
//  landed        out  1   sticky; swarm reached BOTTOM_LIMIT
// BEHAVIOUR
//  - Async reset: topLeftX=INIT_X, topLeftY=INIT_Y, dirRight=1, stepPulse=0, landed=0, frameCnt=0, state=IDLE.
//  - States: IDLE, WAIT, STEP, LANDED. All outputs registered.
//  - IDLE: enable=1 -> WAIT next clk.
//  - WAIT: each startOfFrame: if frameCnt==period-1 -> frameCnt<=0, go STEP; else frameCnt++.
//    If enable=0 -> IDLE, frameCnt<=0, position held.
//  - STEP (exactly 1 clk): nx = X+STEP_X (dirRight) or X-STEP_X.
//    Edge if dirRight && nx+SWARM_WIDTH>RIGHT_BOUND, or !dirRight && nx<LEFT_BOUND.
//    Edge: X unchanged, Y<=Y+STEP_Y, dirRight toggles.
//    No edge: X<=nx.
//    stepPulse=1 in the clk the registers update (one clk after STEP entry).
//    Next state: LANDED if newY+SWARM_HEIGHT>=BOTTOM_LIMIT, else WAIT.
//  - Latency: position changes 2 clks after terminal startOfFrame, well inside vertical blank. No mid-frame tearing.
//  - LANDED: position frozen, landed=1, ignores enable/startOfFrame; only restart exits.
//  - restart (any state): X/Y<=INIT, dirRight<=1, landed<=0, frameCnt<=0, state<=IDLE.
//    restart beats a same-clk step or startOfFrame.
//  - startOfFrame arriving in STEP/IDLE/LANDED is ignored (not counted).
//  - Arithmetic: edge and landing compares in 32-bit signed int; no 11b wrap. X never leaves [LEFT_BOUND, RIGHT_BOUND-SWARM_WIDTH].
// CONFIGURATION
//  SWARM_SPEEDUP_EN defined: aliveCount port exists; period = 2 + (aliveCount>>2).
//    period is sampled on WAIT entry, so fewer invaders -> faster swarm.
//  Undefined: no aliveCount port; period = STEP_FRAMES constant.
// STRUCTURE
//  swarm_pkg: swarm_state_t enum (IDLE,WAIT,STEP,LANDED), SCREEN_W=640, SCREEN_H=480, coordinate width 11.
//  Sub-module frame_divider: frameCnt, period load, terminal-count pulse on startOfFrame.
//  FSM and position regs live in top.
// TESTING
//  1) Reset, enable=1, 30 frames -> X 64->72 after 30th startOfFrame, stepPulse one clk, Y=32.
//  2) Run to right edge: X=288 (288+352=640) step -> Y 32->48, X 288, dirRight=0. Next step -> X=280.
//  3) Y=224 at edge drop (224+16+160=400) -> landed=1, LANDED; further frames leave X/Y unchanged.
//  4) enable=0 mid-count at frameCnt=15 -> IDLE, held; re-enable -> step needs full 30 frames.
//  5) restart same clk as step -> X=64, Y=32, dirRight=1, no stepPulse; reset mid-WAIT -> INIT values.
//  6) SWARM_SPEEDUP_EN, aliveCount=8 -> step every 4 frames; aliveCount=0 -> every 2 frames.

Source files
------------

// File: rtl/swarm_pkg.sv
// swarm_pkg: shared types and screen constants for the invader swarm motion controller
package swarm_pkg;
  localparam int COORD_W = 11;
  localparam int CNT_W = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, WAIT, STEP, LANDED} swarm_state_t;
endpackage

// File: rtl/swarm_move_controller_if.sv
// swarm_move_controller_if: frame/control inputs and swarm position outputs
// aliveCount exists only when SWARM_SPEEDUP_EN is defined
interface swarm_move_controller_if;
  import swarm_pkg::*;
  logic startOfFrame, enable, restart;
  coord_t topLeftX, topLeftY;
  logic stepPulse, dirRight, landed;
`ifdef SWARM_SPEEDUP_EN
  logic [5:0] aliveCount;
  modport master (output startOfFrame, enable, restart, aliveCount,
                  input topLeftX, topLeftY, stepPulse, dirRight, landed);
  modport slave (input startOfFrame, enable, restart, aliveCount,
                 output topLeftX, topLeftY, stepPulse, dirRight, landed);
`else
  modport master (output startOfFrame, enable, restart,
                  input topLeftX, topLeftY, stepPulse, dirRight, landed);
  modport slave (input startOfFrame, enable, restart,
                 output topLeftX, topLeftY, stepPulse, dirRight, landed);
`endif
endinterface

// File: rtl/frame_divider.sv
// frame_divider: counts frames while waiting and flags the terminal frame
// period is captured on load so it stays fixed for one whole step interval
module frame_divider import swarm_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             tick,
  input  logic [CNT_W-1:0] period,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
  always_comb begin
    tc = tick && cnt_q == per_q - 1'b1;
    per_d = load ? period : per_q;
    cnt_d = (clr || tc) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      per_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
endmodule

// File: rtl/swarm_move_controller.sv
// swarm_move_controller: steps the swarm bracket every N frames, drops and reverses at edges
// SWARM_SPEEDUP_EN: period = 2 + (aliveCount>>2) instead of STEP_FRAMES
module swarm_move_controller import swarm_pkg::*; #(
  parameter int INIT_X       = 64,
  parameter int INIT_Y       = 32,
  parameter int SWARM_WIDTH  = 352,
  parameter int SWARM_HEIGHT = 160,
  parameter int STEP_X       = 8,
  parameter int STEP_Y       = 16,
  parameter int STEP_FRAMES  = 30,
  parameter int LEFT_BOUND   = 0,
  parameter int RIGHT_BOUND  = SCREEN_W,
  parameter int BOTTOM_LIMIT = SCREEN_H - 80
) (
  input logic clk,
  input logic resetN,
  swarm_move_controller_if.slave bus
);
  swarm_state_t state_q, state_d;
  coord_t x_q, x_d, y_q, y_d;
  logic dir_q, dir_d, pulse_q, pulse_d, landed_q, landed_d;
  logic tc, tick, clr, load, edge_hit;
  logic [CNT_W-1:0] period;
  int nx, ny;
`ifdef SWARM_SPEEDUP_EN
  assign period = CNT_W'(bus.aliveCount >> 2) + CNT_W'(2);
`else
  assign period = CNT_W'(STEP_FRAMES);
`endif
  assign tick = state_q == WAIT && bus.enable && bus.startOfFrame && !bus.restart;
  assign clr = bus.restart || (state_q == WAIT && !bus.enable);
  assign load = state_d == WAIT && state_q != WAIT;
  frame_divider u_div (.clk, .rst_n(resetN), .clr, .load, .tick, .period, .tc);
  // wide signed math so edge/landing tests never wrap in 11 bits
  always_comb begin
    nx = dir_q ? int'(x_q) + STEP_X : int'(x_q) - STEP_X;
    edge_hit = dir_q ? nx + SWARM_WIDTH > RIGHT_BOUND : nx < LEFT_BOUND;
    ny = edge_hit ? int'(y_q) + STEP_Y : int'(y_q);
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    dir_d = dir_q;
    landed_d = landed_q;
    pulse_d = 1'b0;
    if (bus.restart) begin
      state_d = IDLE;
      x_d = coord_t'(INIT_X);
      y_d = coord_t'(INIT_Y);
      dir_d = 1'b1;
      landed_d = 1'b0;
    end else
      case (state_q)
        IDLE: state_d = bus.enable ? WAIT : IDLE;
        WAIT: state_d = !bus.enable ? IDLE : tc ? STEP : WAIT;
        STEP: begin
          x_d = edge_hit ? x_q : coord_t'(nx);
          y_d = coord_t'(ny);
          dir_d = dir_q ^ edge_hit;
          pulse_d = 1'b1;
          landed_d = ny + SWARM_HEIGHT >= BOTTOM_LIMIT;
          state_d = landed_d ? LANDED : WAIT;
        end
        default: state_d = LANDED;
      endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      x_q <= coord_t'(INIT_X);
      y_q <= coord_t'(INIT_Y);
      dir_q <= 1'b1;
      pulse_q <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dir_q <= dir_d;
      pulse_q <= pulse_d;
      landed_q <= landed_d;
    end
  assign bus.topLeftX = x_q;
  assign bus.topLeftY = y_q;
  assign bus.stepPulse = pulse_q;
  assign bus.dirRight = dir_q;
  assign bus.landed = landed_q;
endmodule

// File: tb/tb_swarm_move_controller.sv
// tb_swarm_move_controller: table, directed and random checks against a frame-level swarm model
module tb_swarm_move_controller;
  logic clk = 1'b0;
  logic resetN;
  swarm_move_controller_if bus ();
  swarm_move_controller dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    int steps;
    int adj;
    int ex;
    int ey;
    bit edir;
    bit eland;
  } vec_t;
  vec_t tbl[9];

  int nvec = 0, nerr = 0, per;
  int m_x, m_y, m_cnt, m_per, m_mode;
  bit m_dir, m_land, m_pulse, ren;

  function automatic int per_now();
`ifdef SWARM_SPEEDUP_EN
    return 2 + int'(bus.aliveCount >> 2);
`else
    return 30;
`endif
  endfunction

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 64; m_y = 32; m_dir = 1; m_land = 0; m_pulse = 0;
    m_mode = 0; m_cnt = 0; m_per = 0;
  endtask

  // mode: 0 idle, 1 counting frames, 2 step pending, 3 landed
  task automatic model_clk(bit sof, bit en, bit rs);
    int nx;
    m_pulse = 0;
    if (rs) model_reset();
    else if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_cnt = 0; m_per = per_now(); end
    end else if (m_mode == 1) begin
      if (!en) begin m_mode = 0; m_cnt = 0; end
      else if (sof) begin
        m_cnt++;
        if (m_cnt == m_per) begin m_cnt = 0; m_mode = 2; end
      end
    end else if (m_mode == 2) begin
      nx = m_dir ? m_x + 8 : m_x - 8;
      if (nx < 0 || nx + 352 > 640) begin m_y += 16; m_dir = !m_dir; end
      else m_x = nx;
      m_pulse = 1;
      if (m_y + 160 >= 400) begin m_land = 1; m_mode = 3; end
      else begin m_mode = 1; m_per = per_now(); end
    end
  endtask

  task automatic check_all();
    chk("x", int'(bus.topLeftX), m_x);
    chk("y", int'(bus.topLeftY), m_y);
    chk("dir", int'(bus.dirRight), int'(m_dir));
    chk("pulse", int'(bus.stepPulse), int'(m_pulse));
    chk("landed", int'(bus.landed), int'(m_land));
  endtask

  task automatic tick(bit sof, bit en, bit rs);
    bus.startOfFrame = sof;
    bus.enable = en;
    bus.restart = rs;
    @(posedge clk);
    model_clk(sof, en, rs);
    #1;
    check_all();
  endtask

  task automatic frames(int n, bit en);
    repeat (n) begin
      tick(1, en, 0);
      tick(0, en, 0);
    end
  endtask

  initial begin
    tbl[0] = '{1, -1, 64, 32, 1, 0};
    tbl[1] = '{0, 1, 72, 32, 1, 0};
    tbl[2] = '{27, 0, 288, 32, 1, 0};
    tbl[3] = '{1, 0, 288, 48, 0, 0};
    tbl[4] = '{1, 0, 280, 48, 0, 0};
    tbl[5] = '{35, 0, 0, 48, 0, 0};
    tbl[6] = '{1, 0, 0, 64, 1, 0};
    tbl[7] = '{407, 0, 288, 240, 0, 1};
    tbl[8] = '{1, 0, 288, 240, 0, 1};
    bus.startOfFrame = 0; bus.enable = 0; bus.restart = 0;
`ifdef SWARM_SPEEDUP_EN
    bus.aliveCount = 6'd8;
`endif
    resetN = 0;
    model_reset();
    #12;
    chk("rst_x", int'(bus.topLeftX), 64);
    chk("rst_y", int'(bus.topLeftY), 32);
    chk("rst_dir", int'(bus.dirRight), 1);
    chk("rst_pulse", int'(bus.stepPulse), 0);
    chk("rst_landed", int'(bus.landed), 0);
    @(posedge clk);
    #1 resetN = 1;
    per = per_now();
    // walk right, drop at the edge, sweep down to the landing line
    for (int i = 0; i < 9; i++) begin
      tick(0, 1, 0);
      frames(tbl[i].steps * per + tbl[i].adj, 1);
      chk($sformatf("tbl%0d_x", i), int'(bus.topLeftX), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(bus.topLeftY), tbl[i].ey);
      chk($sformatf("tbl%0d_dir", i), int'(bus.dirRight), int'(tbl[i].edir));
      chk($sformatf("tbl%0d_landed", i), int'(bus.landed), int'(tbl[i].eland));
    end
    // single-cycle step pulse two clocks after the terminal frame
    tick(0, 0, 1);
    tick(0, 1, 0);
    frames(per - 1, 1);
    tick(1, 1, 0);
    chk("A_pre_pulse", int'(bus.stepPulse), 0);
    chk("A_pre_x", int'(bus.topLeftX), 64);
    tick(0, 1, 0);
    chk("A_pulse", int'(bus.stepPulse), 1);
    chk("A_x", int'(bus.topLeftX), 72);
    tick(0, 1, 0);
    chk("A_post_pulse", int'(bus.stepPulse), 0);
    // disable mid-count: count restarts from zero
    tick(0, 0, 1);
    tick(0, 1, 0);
    frames(per / 2, 1);
    tick(0, 0, 0);
    frames(3, 0);
    chk("B_held_x", int'(bus.topLeftX), 64);
    tick(0, 1, 0);
    frames(per - 1, 1);
    chk("B_partial_x", int'(bus.topLeftX), 64);
    frames(1, 1);
    chk("B_step_x", int'(bus.topLeftX), 72);
    // restart on the same clock the step would commit
    tick(0, 0, 1);
    tick(0, 1, 0);
    frames(per - 1, 1);
    tick(1, 1, 0);
    tick(0, 1, 1);
    chk("C_x", int'(bus.topLeftX), 64);
    chk("C_y", int'(bus.topLeftY), 32);
    chk("C_dir", int'(bus.dirRight), 1);
    chk("C_pulse", int'(bus.stepPulse), 0);
    tick(0, 1, 0);
    frames(per, 1);
    chk("C_after_x", int'(bus.topLeftX), 72);
    // asynchronous reset in the middle of a wait
    frames(3, 1);
    #2 resetN = 0;
    #1;
    chk("D_x", int'(bus.topLeftX), 64);
    chk("D_y", int'(bus.topLeftY), 32);
    chk("D_dir", int'(bus.dirRight), 1);
    chk("D_landed", int'(bus.landed), 0);
    model_reset();
    @(posedge clk);
    #1 resetN = 1;
    ren = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) ren = !ren;
`ifdef SWARM_SPEEDUP_EN
      if ($urandom_range(0, 49) == 0) bus.aliveCount = 6'($urandom_range(0, 63));
`endif
      tick($urandom_range(0, 2) == 0, ren, $urandom_range(0, 799) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
